soc_system_hps_only_master_rsp_timing_adt: RTL and testbench
============================================================

// Module: soc_system_hps_only_master_rsp_timing_adt
// PURPOSE
//   Avalon-ST timing adapter for the return (response) byte stream of the HPS-only master.
//   Upstream uses readyLatency IN_READY_LATENCY; downstream uses readyLatency 0 with full backpressure.
//   A small FIFO absorbs in-flight beats, so no byte is lost while the sink stalls.
//   Beats that break the latency contract are dropped and flagged (sticky overflow).
//   Sits between the response packet path and the byte-to-transport bridge.
// PARAMETERS
//   DATA_W            8  payload width in bits (one byte per beat)
//   DEPTH             4  FIFO entries; power of 2, >= 2
//   IN_READY_LATENCY  1  upstream ready latency; legal values 0 or 1
// PORTS
//   clk        in   1       single clock, all logic rising-edge
//   reset      in   1       synchronous, active-high
//   in_valid   in   1       upstream beat valid
//   in_data    in   DATA_W  upstream payload
//   in_ready   out  1       upstream permission (meaning depends on IN_READY_LATENCY)
//   out_valid  out  1       downstream beat valid
//   out_data   out  DATA_W  downstream payload
//   out_ready  in   1       downstream ready, readyLatency 0
//   overflow   out  1       sticky: a beat arrived without permission and was dropped
// BEHAVIOUR
//   State: count (0..DEPTH), wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), in_ready_q, overflow.
//   Reset (synchronous, while reset=1): count, wr_ptr, rd_ptr, in_ready_q, overflow <= 0.
//     Outputs during reset: in_ready=0, out_valid=0.
//     Mid-operation reset discards all buffered beats; out_data is don't-care while out_valid=0.
//   Output side:
//     out_valid = (count != 0)
//     out_data  = mem[rd_ptr] (first-word fall-through)
//     pop = out_valid & out_ready
//   IN_READY_LATENCY=0:
//     in_ready = !reset & (count < DEPTH)
//     push = in_valid & in_ready
//     in_valid & !in_ready is a legal wait, not an overflow
//   IN_READY_LATENCY=1:
//     in_ready = !reset & (count <= DEPTH-2)
//     in_ready_q <= in_ready
//     push = in_valid & in_ready_q
//     in_valid & !in_ready_q: beat dropped, overflow <= 1
//     Headroom argument: at most one permitted beat is ever in flight, so a permitted beat
//       always finds a free slot.
//   Push writes mem[wr_ptr] and increments wr_ptr; pop increments rd_ptr.
//     Push and pop in the same cycle: count unchanged, both pointers advance.
//   Full (count=DEPTH): no push is possible; a pop still proceeds.
//     With latency 0, in_ready re-asserts in the cycle after the pop.
//   Empty: out_valid=0; out_ready is ignored.
//   No in->out bypass: minimum latency is 1 cycle (data pushed at edge t is visible after t).
//   Throughput: 1 beat/clk sustained while out_ready=1 (both latency settings).
//   overflow clears only on reset; it never blocks traffic.
//   Payload ordering is strictly FIFO; no beat is duplicated.
// STRUCTURE
//   Shared package soc_system_hps_only_master_pkg:
//     byte width constant (8)
//     ready-latency enum {RL0, RL1}
//   Sub-module soc_system_hps_only_master_rsp_fifo (DATA_W, DEPTH):
//     owns mem, pointers and count
//     exposes push, pop, count, rd_data
//   Top level adds in_ready generation, the in_ready_q latency tracking and the overflow flag.
// TESTING
//   1. Reset, then 0x11,0x22,0x33 with out_ready=1 (RL1)
//        -> out_data 0x11,0x22,0x33 in order; each beat one cycle after acceptance;
//           overflow=0.
//   2. out_ready=0, upstream streams while permitted (DEPTH=4, RL1)
//        -> in_ready falls when count reaches 3; the in-flight 4th beat is accepted;
//           count=4; no drop; then out_ready=1 drains 4 beats in order.
//   3. RL1: in_valid with 0x5A in the cycle after in_ready=0
//        -> beat dropped, overflow=1 and stays 1; subsequent legal beats still pass.
//   4. Continuous push+pop at count=2 for 10 cycles
//        -> count stays 2; pointers wrap past DEPTH-1; output sequence is intact.
//   5. reset asserted with count=3
//        -> next cycle: out_valid=0, in_ready=0, overflow=0; after release, a new beat
//           0x77 is the first one out.
//   6. RL0, DEPTH=2: full with out_ready=1 and in_valid=1 held
//        -> alternating pop/accept; no beat lost, no overflow.

Source files
------------

// File: rtl/soc_system_hps_only_master_pkg.sv
// Shared definitions for the HPS-only master response path.
package soc_system_hps_only_master_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        RL0 = 1'b0,
        RL1 = 1'b1
    } ready_latency_e;

endpackage

// File: rtl/soc_system_hps_only_master_rsp_fifo.sv
// First-word fall-through FIFO holding response bytes; pointers wrap naturally.
module soc_system_hps_only_master_rsp_fifo
    import soc_system_hps_only_master_pkg::*;
#(
    parameter  int DATA_W = BYTE_W,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_pop,
    output logic [CW-1:0]     o_count,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (i_pop && !i_push) r_count <= r_count - 1'b1;
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/soc_system_hps_only_master_rsp_timing_adt.sv
// Avalon-ST timing adapter: upstream readyLatency 0/1 into a readyLatency-0 sink,
// buffering in-flight beats and flagging beats sent without permission.
module soc_system_hps_only_master_rsp_timing_adt
    import soc_system_hps_only_master_pkg::*;
#(
    parameter int DATA_W           = BYTE_W,
    parameter int DEPTH            = 4,
    parameter int IN_READY_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int             CW = $clog2(DEPTH + 1);
    localparam ready_latency_e RL = (IN_READY_LATENCY == 1) ? RL1 : RL0;
    // With latency 1 one slot is held back for the beat already in flight.
    localparam logic [CW-1:0]  LIMIT_C = (RL == RL1) ? CW'(DEPTH - 2) : CW'(DEPTH - 1);

    logic [CW-1:0] w_count;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          r_in_ready_q;
    logic          r_overflow;

    assign w_in_ready = !reset && (w_count <= LIMIT_C);
    assign w_push     = in_valid && ((RL == RL1) ? r_in_ready_q : w_in_ready);
    assign w_drop     = (RL == RL1) && in_valid && !r_in_ready_q;
    assign w_pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready_q <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_in_ready_q <= w_in_ready;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    soc_system_hps_only_master_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_wr_data (in_data),
        .i_pop     (w_pop),
        .o_count   (w_count),
        .o_rd_data (out_data)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = (w_count != '0);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_soc_system_hps_only_master_rsp_timing_adt.sv
// Bench for the response timing adapter: RL1/DEPTH=4 and RL0/DEPTH=2 instances
// checked against queue-based reference models plus directed literal expectations.
module tb_soc_system_hps_only_master_rsp_timing_adt;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_iv, a_or, a_in_ready, a_out_valid, a_overflow;
    logic [7:0] a_id, a_out_data;
    logic       b_iv, b_or, b_in_ready, b_out_valid, b_overflow;
    logic [7:0] b_id, b_out_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_system_hps_only_master_rsp_timing_adt #(
        .DATA_W(8), .DEPTH(4), .IN_READY_LATENCY(1)
    ) dut_a (
        .clk(clk), .reset(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_or), .overflow(a_overflow)
    );

    soc_system_hps_only_master_rsp_timing_adt #(
        .DATA_W(8), .DEPTH(2), .IN_READY_LATENCY(0)
    ) dut_b (
        .clk(clk), .reset(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_or), .overflow(b_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference models: plain queues of buffered bytes.
    byte unsigned aq[$];
    byte unsigned bq[$];
    bit           a_perm = 1'b0;
    bit           a_ovf  = 1'b0;
    bit           a_rdy_m;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            aq.delete();
            bq.delete();
            a_perm = 1'b0;
            a_ovf  = 1'b0;
        end else begin
            a_rdy_m = (aq.size() <= 2);
            if (a_iv && !a_perm) a_ovf = 1'b1;
            if (aq.size() != 0 && a_or) void'(aq.pop_front());
            if (a_iv && a_perm) aq.push_back(a_id);
            a_perm = a_rdy_m;
            if (b_iv && bq.size() < 2) begin
                if (bq.size() != 0 && b_or) void'(bq.pop_front());
                bq.push_back(b_id);
            end else if (bq.size() != 0 && b_or) begin
                void'(bq.pop_front());
            end
        end
    end

    byte unsigned alog[$];
    byte unsigned blog[$];
    logic         a_rdy_prev = 1'b0;
    int           b_sent = 0;

    // Compare every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("a_in_ready", a_in_ready, !rst && (aq.size() <= 2));
        chk("a_out_valid", a_out_valid, aq.size() != 0);
        if (aq.size() != 0) chk("a_out_data", a_out_data, aq[0]);
        chk("a_overflow", a_overflow, a_ovf);
        chk("b_in_ready", b_in_ready, !rst && (bq.size() < 2));
        chk("b_out_valid", b_out_valid, bq.size() != 0);
        if (bq.size() != 0) chk("b_out_data", b_out_data, bq[0]);
        chk("b_overflow", b_overflow, 1'b0);
        if (!rst && a_out_valid && a_or) alog.push_back(a_out_data);
        if (!rst && b_out_valid && b_or) blog.push_back(b_out_data);
        if (!rst && b_iv && b_in_ready) b_sent++;
        a_rdy_prev = a_in_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        tick();
        a_iv = 1'b0;
    endtask

    // Present one beat on the first cycle the latency-1 contract permits it.
    task automatic a_send(input logic [7:0] d);
        logic sent;
        sent = 1'b0;
        for (int k = 0; k < 16 && !sent; k++) begin
            tick();
            a_iv = a_rdy_prev;
            a_id = d;
            sent = a_rdy_prev;
        end
        chk("a_send_permitted", sent, 1'b1);
    endtask

    task automatic a_stream(input logic [7:0] base, input int ncyc, output int acc);
        acc = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            a_iv = a_rdy_prev;
            a_id = base + 8'(acc);
            if (a_rdy_prev) acc++;
        end
        a_idle();
    endtask

    int cnt;

    initial begin
        rst = 1'b1;
        a_iv = 1'b0; a_id = 8'h00; a_or = 1'b0;
        b_iv = 1'b0; b_id = 8'h00; b_or = 1'b0;
        repeat (3) tick();
        chk("rst_a_in_ready", a_in_ready, 1'b0);
        chk("rst_a_out_valid", a_out_valid, 1'b0);
        chk("rst_b_in_ready", b_in_ready, 1'b0);
        rst = 1'b0;

        // 1: three beats straight through
        a_or = 1'b1;
        alog.delete();
        a_send(8'h11); a_send(8'h22); a_send(8'h33);
        a_idle();
        repeat (3) tick();
        chk("t1_len", alog.size(), 3);
        chk("t1_b0", alog[0], 8'h11);
        chk("t1_b1", alog[1], 8'h22);
        chk("t1_b2", alog[2], 8'h33);
        chk("t1_ovf", a_overflow, 1'b0);

        // 2: stall the sink, upstream streams while permitted
        a_or = 1'b0;
        alog.delete();
        a_stream(8'hA0, 8, cnt);
        chk("t2_accepted", cnt, 4);
        chk("t2_full_in_ready", a_in_ready, 1'b0);
        chk("t2_full_out_valid", a_out_valid, 1'b1);
        chk("t2_ovf", a_overflow, 1'b0);
        a_or = 1'b1;
        repeat (6) tick();
        chk("t2_len", alog.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_b%0d", i), alog[i], 8'hA0 + i);

        // 3: beat without permission is dropped and flagged
        a_or = 1'b0;
        alog.delete();
        a_stream(8'hB0, 8, cnt);
        tick();
        a_iv = 1'b1;
        a_id = 8'h5A;
        a_idle();
        chk("t3_ovf", a_overflow, 1'b1);
        a_or = 1'b1;
        repeat (6) tick();
        a_send(8'hC1);
        a_idle();
        repeat (3) tick();
        chk("t3_ovf_sticky", a_overflow, 1'b1);
        chk("t3_len", alog.size(), 5);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_b%0d", i), alog[i], 8'hB0 + i);
        chk("t3_b4", alog[4], 8'hC1);

        // 4: steady push+pop at two buffered beats
        a_or = 1'b0;
        alog.delete();
        a_send(8'hD0); a_send(8'hD1);
        a_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            a_or = 1'b1;
            a_iv = 1'b1;
            a_id = 8'hD2 + 8'(i);
        end
        a_idle();
        repeat (4) tick();
        chk("t4_len", alog.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t4_b%0d", i), alog[i], 8'hD0 + i);

        // 5: reset with three beats buffered
        a_or = 1'b0;
        a_send(8'hE0); a_send(8'hE1); a_send(8'hE2);
        a_idle();
        rst = 1'b1;
        chk("t5_in_ready_in_rst", a_in_ready, 1'b0);
        tick();
        chk("t5_out_valid", a_out_valid, 1'b0);
        chk("t5_in_ready", a_in_ready, 1'b0);
        chk("t5_ovf", a_overflow, 1'b0);
        rst = 1'b0;
        alog.delete();
        a_or = 1'b1;
        a_send(8'h77);
        a_idle();
        repeat (3) tick();
        chk("t5_len", alog.size(), 1);
        chk("t5_first", alog[0], 8'h77);

        // 6: latency-0, depth-2 instance held full with in_valid asserted
        blog.delete();
        b_sent = 0;
        tick();
        b_iv = 1'b1;
        b_id = 8'h30;
        for (int i = 0; i < 3; i++) begin
            tick();
            b_id = 8'h30 + 8'(b_sent);
        end
        chk("t6_full_in_ready", b_in_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            b_or = 1'b1;
            b_id = 8'h30 + 8'(b_sent);
        end
        tick();
        b_iv = 1'b0;
        repeat (4) tick();
        chk("t6_sent", b_sent, 11);
        chk("t6_len", blog.size(), 11);
        for (int i = 0; i < 11; i++) chk($sformatf("t6_b%0d", i), blog[i], 8'h30 + i);
        chk("t6_ovf", b_overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
